// File: rtl/gate_test_pkg.sv
// Shared types and constants for the 2-input gate exerciser blocks.
// Truth tables are indexed by {in2,in1}.
package gate_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_WAIT,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_XOR  = 4'b0110;

    localparam int unsigned ERR_W = 8;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous bit.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/gate2_checker.sv
// Closed-loop exerciser for a 2-input gate: sweeps all input vectors,
// samples the synchronised gate output after a settle window, and scores it.
module gate2_checker
    import gate_test_pkg::*;
#(
    parameter logic [3:0]  TRUTH  = TT_OR,
    parameter int unsigned SETTLE = 3,
    parameter int unsigned PASSES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             dut_in1,
    output logic             dut_in2,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_vec
);

    localparam logic [7:0] WAIT_LOAD = 8'(SETTLE - 1);
    localparam logic [7:0] LAST_PASS = 8'(PASSES - 1);

    state_t           state_q, state_d;
    logic [1:0]       vec_q, vec_d;
    logic [7:0]       passcnt_q, passcnt_d;
    logic [7:0]       wait_q, wait_d;
    logic             in1_q, in1_d;
    logic             in2_q, in2_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [3:0]       fail_q, fail_d;
    logic             out_sync;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (dut_out),
        .q   (out_sync)
    );

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        passcnt_d = passcnt_q;
        wait_d    = wait_q;
        in1_d     = in1_q;
        in2_d     = in2_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        err_d     = err_q;
        fail_d    = fail_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_APPLY;
                    vec_d     = '0;
                    passcnt_d = '0;
                    err_d     = '0;
                    fail_d    = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                end
            end
            ST_APPLY: begin
                in1_d   = vec_q[0];
                in2_d   = vec_q[1];
                wait_d  = WAIT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (out_sync != TRUTH[vec_q]) begin
                    err_d         = sat_inc(err_q);
                    fail_d[vec_q] = 1'b1;
                end
                if (vec_q == 2'd3 && passcnt_q == LAST_PASS) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    // pass must reflect this final sample's score too
                    pass_d  = (err_d == '0);
                end else begin
                    vec_d   = vec_q + 1'b1;
                    state_d = ST_APPLY;
                    if (vec_q == 2'd3) begin
                        passcnt_d = passcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            vec_q     <= '0;
            passcnt_q <= '0;
            wait_q    <= '0;
            in1_q     <= 1'b0;
            in2_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            fail_q    <= '0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            passcnt_q <= passcnt_d;
            wait_q    <= wait_d;
            in1_q     <= in1_d;
            in2_q     <= in2_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            fail_q    <= fail_d;
        end
    end

    assign dut_in1   = in1_q;
    assign dut_in2   = in2_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate2_checker.sv
// Directed self-checking bench for gate2_checker using four configured instances
// attached to ideal, stuck-at-0 and mismatched gate models.
module tb_gate2_checker;
    import gate_test_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // A: ideal OR, PASSES=1
    logic rst_a = 1'b1, start_a = 1'b0;
    logic in1_a, in2_a, out_a, busy_a, done_a, pass_a;
    logic [7:0] err_a;
    logic [3:0] fail_a;
    assign out_a = in1_a | in2_a;

    // B: OR, PASSES=4, switchable stuck-at-0
    logic rst_b = 1'b1, start_b = 1'b0, stuck_b = 1'b0;
    logic in1_b, in2_b, out_b, busy_b, done_b, pass_b;
    logic [7:0] err_b;
    logic [3:0] fail_b;
    assign out_b = stuck_b ? 1'b0 : (in1_b | in2_b);

    // C: expects NOR, OR gate attached
    logic rst_c = 1'b1, start_c = 1'b0;
    logic in1_c, in2_c, out_c, busy_c, done_c, pass_c;
    logic [7:0] err_c;
    logic [3:0] fail_c;
    assign out_c = in1_c | in2_c;

    // D: stuck-at-0, PASSES=100
    logic rst_d = 1'b1, start_d = 1'b0;
    logic in1_d, in2_d, out_d, busy_d, done_d, pass_d;
    logic [7:0] err_d;
    logic [3:0] fail_d;
    assign out_d = 1'b0;

    gate2_checker #(.TRUTH(TT_OR), .SETTLE(3), .PASSES(1)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .dut_in1(in1_a), .dut_in2(in2_a),
        .dut_out(out_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .fail_vec(fail_a));

    gate2_checker #(.TRUTH(TT_OR), .SETTLE(3), .PASSES(4)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .dut_in1(in1_b), .dut_in2(in2_b),
        .dut_out(out_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .fail_vec(fail_b));

    gate2_checker #(.TRUTH(TT_NOR), .SETTLE(3), .PASSES(4)) dut_c (
        .clk(clk), .rst(rst_c), .start(start_c), .dut_in1(in1_c), .dut_in2(in2_c),
        .dut_out(out_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .err_count(err_c), .fail_vec(fail_c));

    gate2_checker #(.TRUTH(TT_OR), .SETTLE(3), .PASSES(100)) dut_d (
        .clk(clk), .rst(rst_d), .start(start_d), .dut_in1(in1_d), .dut_in2(in2_d),
        .dut_out(out_d), .busy(busy_d), .done(done_d), .pass(pass_d),
        .err_count(err_d), .fail_vec(fail_d));

    // Pulses start_b, optionally re-pulses it at cycle restart_at, and counts
    // cycles from the first APPLY edge until done (bounded by limit).
    task automatic run_b(input int restart_at, input int limit, output int cycles);
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        cycles = 0;
        while (!done_b && cycles < limit) begin
            @(negedge clk);
            cycles++;
            start_b = (cycles == restart_at);
        end
        start_b = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({busy_a, done_a, pass_a, err_a, fail_a, in1_a, in2_a} !== 17'd0) begin
            errors++; $display("FAIL reset_a: got %b expected 0", {busy_a, done_a, pass_a, err_a, fail_a, in1_a, in2_a});
        end
        checks++;
        if ({busy_b, done_b, pass_b, err_b, fail_b, in1_b, in2_b} !== 17'd0) begin
            errors++; $display("FAIL reset_b: got %b expected 0", {busy_b, done_b, pass_b, err_b, fail_b, in1_b, in2_b});
        end
        checks++;
        if ({busy_c, done_c, pass_c, err_c, fail_c, in1_c, in2_c} !== 17'd0) begin
            errors++; $display("FAIL reset_c: got %b expected 0", {busy_c, done_c, pass_c, err_c, fail_c, in1_c, in2_c});
        end
        checks++;
        if ({busy_d, done_d, pass_d, err_d, fail_d, in1_d, in2_d} !== 17'd0) begin
            errors++; $display("FAIL reset_d: got %b expected 0", {busy_d, done_d, pass_d, err_d, fail_d, in1_d, in2_d});
        end
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ideal_or();
        int n;
        logic [1:0] seen [4];
        for (int k = 0; k < 4; k++) seen[k] = 2'bxx;
        start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        checks++;
        if (busy_a !== 1'b1 || done_a !== 1'b0) begin
            errors++; $display("FAIL a_busy_rise: busy=%b done=%b expected busy=1 done=0", busy_a, done_a);
        end
        n = 0;
        while (!done_a && n < 200) begin
            @(negedge clk);
            n++;
            if (n % 5 == 2 && n / 5 < 4) seen[n / 5] = {in2_a, in1_a};
        end
        checks++;
        if (n != 20) begin
            errors++; $display("FAIL a_run_length: got %0d cycles expected 20", n);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (seen[k] !== 2'(k)) begin
                errors++; $display("FAIL a_vector_%0d: got %b expected %b", k, seen[k], 2'(k));
            end
        end
        checks++;
        if ({busy_a, done_a, pass_a} !== 3'b011 || err_a !== 8'd0 || fail_a !== 4'b0000) begin
            errors++; $display("FAIL a_result: busy/done/pass=%b err=%0d fail=%b expected 011 0 0000",
                               {busy_a, done_a, pass_a}, err_a, fail_a);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({in2_a, in1_a} !== 2'b11 || done_a !== 1'b1) begin
            errors++; $display("FAIL a_hold: in=%b done=%b expected 11 1", {in2_a, in1_a}, done_a);
        end
    endtask

    task automatic test_stuck_at_0();
        int n;
        stuck_b = 1'b1;
        run_b(-1, 500, n);
        checks++;
        if (n != 80) begin
            errors++; $display("FAIL b_stuck_length: got %0d expected 80", n);
        end
        checks++;
        if (err_b !== 8'd12 || fail_b !== 4'b1110 || pass_b !== 1'b0 || done_b !== 1'b1) begin
            errors++; $display("FAIL b_stuck_result: err=%0d fail=%b pass=%b done=%b expected 12 1110 0 1",
                               err_b, fail_b, pass_b, done_b);
        end
    endtask

    task automatic test_nor_truth();
        int n;
        @(negedge clk); start_c = 1'b1;
        @(negedge clk); start_c = 1'b0;
        n = 0;
        while (!done_c && n < 500) begin @(negedge clk); n++; end
        checks++;
        if (err_c !== 8'd16 || fail_c !== 4'b1111 || pass_c !== 1'b0 || done_c !== 1'b1) begin
            errors++; $display("FAIL c_nor_result: err=%0d fail=%b pass=%b done=%b expected 16 1111 0 1",
                               err_c, fail_c, pass_c, done_c);
        end
    endtask

    task automatic test_saturation();
        int n;
        @(negedge clk); start_d = 1'b1;
        @(negedge clk); start_d = 1'b0;
        n = 0;
        while (!done_d && n < 3000) begin @(negedge clk); n++; end
        checks++;
        if (n != 2000) begin
            errors++; $display("FAIL d_run_length: got %0d expected 2000", n);
        end
        checks++;
        if (err_d !== 8'd255 || fail_d !== 4'b1110 || pass_d !== 1'b0) begin
            errors++; $display("FAIL d_saturate: err=%0d fail=%b pass=%b expected 255 1110 0", err_d, fail_d, pass_d);
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        stuck_b = 1'b1;
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        repeat (27) @(negedge clk);
        rst_b = 1'b1;
        #1;
        checks++;
        if ({busy_b, done_b, pass_b, err_b, fail_b, in1_b, in2_b} !== 17'd0) begin
            errors++; $display("FAIL b_abort: got %b expected 0", {busy_b, done_b, pass_b, err_b, fail_b, in1_b, in2_b});
        end
        @(negedge clk);
        rst_b = 1'b0;
        stuck_b = 1'b0;
        run_b(-1, 500, n);
        checks++;
        if (n != 80 || pass_b !== 1'b1 || err_b !== 8'd0 || fail_b !== 4'b0000) begin
            errors++; $display("FAIL b_after_abort: cycles=%0d pass=%b err=%0d fail=%b expected 80 1 0 0000",
                               n, pass_b, err_b, fail_b);
        end
    endtask

    task automatic test_start_while_busy();
        int n;
        stuck_b = 1'b0;
        run_b(2, 500, n);
        checks++;
        if (n != 80 || pass_b !== 1'b1 || err_b !== 8'd0) begin
            errors++; $display("FAIL b_start_in_wait: cycles=%0d pass=%b err=%0d expected 80 1 0", n, pass_b, err_b);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        stuck_b = 1'b1;
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        checks++;
        if (done_b !== 1'b0 || busy_b !== 1'b1 || pass_b !== 1'b0 || err_b !== 8'd0) begin
            errors++; $display("FAIL b_restart_clear: done=%b busy=%b pass=%b err=%0d expected 0 1 0 0",
                               done_b, busy_b, pass_b, err_b);
        end
        n = 0;
        while (!done_b && n < 500) begin @(negedge clk); n++; end
        checks++;
        if (n != 80 || err_b !== 8'd12 || fail_b !== 4'b1110) begin
            errors++; $display("FAIL b_restart_run: cycles=%0d err=%0d fail=%b expected 80 12 1110", n, err_b, fail_b);
        end
    endtask

    initial begin
        test_reset();
        test_ideal_or();
        test_stuck_at_0();
        test_nor_truth();
        test_saturation();
        test_reset_mid_run();
        test_start_while_busy();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
